// File: rtl/temporal_encoder_pkg.sv
// Shared types and defaults for the temporal (N-gram) encoder.
package temporal_encoder_pkg;

  localparam int DEFAULT_HV_DIMENSION = 2048;
  localparam int DEFAULT_NGRAM        = 3;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    ENCODE        = 2'd1,
    OUTPUT_STABLE = 2'd2
  } tencState_t;

  // Smallest r with 2**r >= value; sizes the fill counter so it can hold NGRAM itself.
  function automatic int ceilLog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hv_permute.sv
// Combinational rotate of a hypervector by SHIFT positions toward higher index (wraps modulo D).
// Zero latency, no flow control; out[i] = in[(i - SHIFT) mod D].
module hv_permute #(
  parameter int HV_DIMENSION = 8,
  parameter int SHIFT        = 1
) (
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

  localparam int ROT = SHIFT % HV_DIMENSION;

  for (genvar i = 0; i < HV_DIMENSION; i++) begin : gen_bit
    assign HypervectorOut_DO[i] = HypervectorIn_DI[(i + HV_DIMENSION - ROT) % HV_DIMENSION];
  end

endmodule

// File: rtl/temporal_encoder.sv
// N-gram encoder: XOR of rho^k(H[k]) over an NGRAM-deep history; ValidOut 2 cycles after the filling accept.
// Accepts input only in IDLE; output held until ReadyIn. TENC_SLIDING_EN selects sliding vs tumbling window.
module temporal_encoder
  import temporal_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = DEFAULT_HV_DIMENSION,
  parameter int NGRAM        = DEFAULT_NGRAM
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

  localparam int                   CNT_WIDTH = ceilLog2(NGRAM + 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(NGRAM);

`ifdef TENC_SLIDING_EN
  localparam bit SLIDING_WINDOW = 1'b1;
`else
  localparam bit SLIDING_WINDOW = 1'b0;
`endif

  tencState_t                State_SP, State_SN;
  logic [CNT_WIDTH-1:0]      FillCntr_SP;
  logic [CNT_WIDTH-1:0]      FillCntrInc_S;
  logic [0:HV_DIMENSION-1]   History_DP [NGRAM];
  logic [0:HV_DIMENSION-1]   Permuted_D [NGRAM];
  logic [0:HV_DIMENSION-1]   NGram_D;
  logic                      Accept_S;
  logic                      Handshake_S;

  assign Accept_S      = (State_SP == IDLE) && ValidIn_SI;
  assign Handshake_S   = (State_SP == OUTPUT_STABLE) && ReadyIn_SI;
  assign FillCntrInc_S = (FillCntr_SP == FULL_CNT) ? FULL_CNT : FillCntr_SP + 1'b1;

  // H[0] is the newest sample and is used unrotated.
  assign Permuted_D[0] = History_DP[0];
  for (genvar k = 1; k < NGRAM; k++) begin : gen_permute
    hv_permute #(
      .HV_DIMENSION(HV_DIMENSION),
      .SHIFT       (k)
    ) i_hv_permute (
      .HypervectorIn_DI (History_DP[k]),
      .HypervectorOut_DO(Permuted_D[k])
    );
  end

  always_comb begin
    NGram_D = '0;
    for (int k = 0; k < NGRAM; k++) begin
      NGram_D = NGram_D ^ Permuted_D[k];
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      State_SP <= IDLE;
    end else begin
      State_SP <= State_SN;
    end
  end

  always_comb begin
    State_SN = State_SP;
    unique case (State_SP)
      IDLE:          if (Accept_S && (FillCntrInc_S == FULL_CNT)) State_SN = ENCODE;
      ENCODE:        State_SN = OUTPUT_STABLE;
      OUTPUT_STABLE: if (ReadyIn_SI) State_SN = IDLE;
      default:       State_SN = IDLE;
    endcase
  end

  always_comb begin
    ReadyOut_SO = 1'b0;
    ValidOut_SO = 1'b0;
    unique case (State_SP)
      IDLE:          ReadyOut_SO = 1'b1;
      OUTPUT_STABLE: ValidOut_SO = 1'b1;
      default:       ;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      FillCntr_SP       <= '0;
      HypervectorOut_DO <= '0;
      for (int k = 0; k < NGRAM; k++) History_DP[k] <= '0;
    end else begin
      if (Accept_S) begin
        History_DP[0] <= HypervectorIn_DI;
        for (int k = 1; k < NGRAM; k++) History_DP[k] <= History_DP[k-1];
        FillCntr_SP <= FillCntrInc_S;
      end else if (Handshake_S && !SLIDING_WINDOW) begin
        // Tumbling window: next output is built from fresh samples only.
        FillCntr_SP <= '0;
        for (int k = 0; k < NGRAM; k++) History_DP[k] <= '0;
      end
      if (State_SP == ENCODE) begin
        HypervectorOut_DO <= NGram_D;
      end
    end
  end

endmodule
